// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns one register read/write request into the command/strobe
// sequence of an upstream i2c_master (START+addr, reg byte, optional repeated
// START, data bytes). Optional macro I2C_SEQ_RETRY_EN: restart the transaction
// after arbitration loss, up to N_RETRY times, while no write byte was taken.
`timescale 1ns/1ps
module i2c_reg_seq #(
  parameter int LEN_W   = 4,
  parameter int N_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic             rnw_in,
  input  logic [6:0]       dev_in,
  input  logic [7:0]       reg_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [7:0]       wdat_in,
  output logic             wdat_take_out,
  output logic [7:0]       rdat_out,
  output logic             rdat_vld_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             err_out,
  output logic             nack_out,
  output logic             alo_out,
  output logic [4:0]       cmd_out,
  output logic [7:0]       mdat_out,
  output logic             ws_out,
  input  logic [3:0]       stat_in,
  input  logic [7:0]       mdat_in
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAITS, S_WAITD, S_EVAL, S_STOPX, S_CLR, S_FIN} state_e;
  typedef enum logic [2:0] {P_ADDR, P_REG, P_WDAT, P_RADDR, P_RDAT, P_STOP} phase_e;

  state_e state_q, state_d;
  phase_e phase_q, phase_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic rnw_q, rnw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [4:0] cmd_q, cmd_d;
  logic [7:0] mdat_q, mdat_d;
  logic ws_q, ws_d, take_q, take_d, rvld_q, rvld_d;
  logic [7:0] rdat_q, rdat_d;
  logic busy_q, busy_d, done_q, done_d;
  logic err_q, err_d, nack_q, nack_d, alo_q, alo_d;
  logic hold_q, hold_d;
  logic wr_phase_s;
`ifdef I2C_SEQ_RETRY_EN
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0] retry_q, retry_d;
  logic took_q, took_d;
`else
  logic unused_retry_s;
  assign unused_retry_s = (N_RETRY > 0);
`endif

  // Phases in which the master transmits and the slave must ACK
  assign wr_phase_s = (phase_q == P_ADDR) || (phase_q == P_REG) ||
                      (phase_q == P_WDAT) || (phase_q == P_RADDR);

  // Next-state, phase sequencing and output-register updates
  always_comb begin
    state_d = state_q;  phase_d = phase_q;  cnt_d = cnt_q;
    rnw_d = rnw_q;  dev_d = dev_q;  reg_d = reg_q;
    cmd_d = cmd_q;  mdat_d = mdat_q;  ws_d = 1'b0;  take_d = 1'b0;
    rdat_d = rdat_q;  rvld_d = 1'b0;  busy_d = busy_q;  done_d = 1'b0;
    err_d = err_q;  nack_d = nack_q;  alo_d = alo_q;  hold_d = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
    len_d = len_q;  retry_d = retry_q;  took_d = took_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_in) begin
          rnw_d = rnw_in;  dev_d = dev_in;  reg_d = reg_in;  cnt_d = len_in;
          phase_d = P_ADDR;  busy_d = 1'b1;
          err_d = 1'b0;  nack_d = 1'b0;  alo_d = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
          len_d = len_in;  retry_d = 8'd0;  took_d = 1'b0;
`endif
          // A zero-length read has nothing to do: reject without bus activity
          if (rnw_in && (len_in == '0)) begin
            err_d = 1'b1;  state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        // Freeze the consumed write byte so mdat_out stays stable after the strobe
        if (phase_q == P_WDAT) begin
          mdat_d = wdat_in;
`ifdef I2C_SEQ_RETRY_EN
          took_d = 1'b1;
`endif
        end else begin
          mdat_d = mdat_q;
        end
        state_d = S_WAITS;
      end
      S_WAITS: begin
        if (stat_in[1])      state_d = S_EVAL;
        else if (stat_in[0]) state_d = S_WAITD;
        else                 state_d = S_WAITS;
      end
      S_WAITD: begin
        if (!stat_in[0]) state_d = S_EVAL;
        else             state_d = S_WAITD;
      end
      S_EVAL: begin
        if (stat_in[1]) begin
          state_d = S_CLR;  ws_d = 1'b1;  cmd_d = 5'h00;  mdat_d = 8'h00;
`ifdef I2C_SEQ_RETRY_EN
          // err_q stays 0 on a retry; CLR uses that to choose restart vs finish
          if (stat_in[2] && !took_q && (retry_q < 8'(N_RETRY))) begin
            retry_d = retry_q + 8'd1;
          end else begin
            err_d = 1'b1;  alo_d = stat_in[2];
          end
`else
          err_d = 1'b1;  alo_d = stat_in[2];
`endif
        end else if (wr_phase_s && !stat_in[3]) begin
          nack_d = 1'b1;  err_d = 1'b1;
          state_d = cmd_q[1] ? S_FIN : S_STOPX;
        end else begin
          if (phase_q == P_RDAT) begin
            rdat_d = mdat_in;  rvld_d = 1'b1;
          end else begin
            rdat_d = rdat_q;
          end
          case (phase_q)
            P_ADDR:  begin phase_d = P_REG;  state_d = S_ISSUE; end
            P_REG: begin
              if (rnw_q)                  begin phase_d = P_RADDR; state_d = S_ISSUE; end
              else if (cnt_q == '0)       state_d = S_FIN;
              else                        begin phase_d = P_WDAT;  state_d = S_ISSUE; end
            end
            P_WDAT, P_RDAT: begin
              cnt_d = cnt_q - LEN_W'(1);
              if (cnt_q == LEN_W'(1)) state_d = S_FIN;
              else                    state_d = S_ISSUE;
            end
            P_RADDR: begin phase_d = P_RDAT; state_d = S_ISSUE; end
            default: state_d = S_FIN;
          endcase
        end
      end
      S_STOPX: begin
        phase_d = P_STOP;  state_d = S_ISSUE;
      end
      S_CLR: begin
        // First cycle carries the clear strobe, second cycle lets status settle
        if (!hold_q) begin
          hold_d = 1'b1;  state_d = S_CLR;
        end else begin
`ifdef I2C_SEQ_RETRY_EN
          if (!err_q) begin
            phase_d = P_ADDR;  cnt_d = len_q;  state_d = S_ISSUE;
          end else begin
            state_d = S_FIN;
          end
`else
          state_d = S_FIN;
`endif
        end
      end
      S_FIN: begin
        done_d = 1'b1;  busy_d = 1'b0;  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Load the master command for the phase about to be issued
    if (state_d == S_ISSUE) begin
      ws_d = 1'b1;
      case (phase_d)
        P_ADDR:  begin cmd_d = 5'h09; mdat_d = {dev_d, 1'b0}; end
        P_REG:   begin cmd_d = (!rnw_d && (cnt_d == '0)) ? 5'h0A : 5'h08; mdat_d = reg_d; end
        P_WDAT:  begin cmd_d = (cnt_d == LEN_W'(1)) ? 5'h0A : 5'h08; take_d = 1'b1; end
        P_RADDR: begin cmd_d = 5'h09; mdat_d = {dev_q, 1'b1}; end
        P_RDAT:  begin cmd_d = (cnt_d == LEN_W'(1)) ? 5'h16 : 5'h04; mdat_d = 8'hFF; end
        default: begin cmd_d = 5'h02; mdat_d = 8'h00; end
      endcase
    end else begin
      ws_d = ws_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;  phase_q <= P_ADDR;  cnt_q <= '0;
      rnw_q <= 1'b0;  dev_q <= 7'h00;  reg_q <= 8'h00;
      cmd_q <= 5'h00;  mdat_q <= 8'h00;  ws_q <= 1'b0;  take_q <= 1'b0;
      rdat_q <= 8'h00;  rvld_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;
      err_q <= 1'b0;  nack_q <= 1'b0;  alo_q <= 1'b0;  hold_q <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
      len_q <= '0;  retry_q <= 8'd0;  took_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  phase_q <= phase_d;  cnt_q <= cnt_d;
      rnw_q <= rnw_d;  dev_q <= dev_d;  reg_q <= reg_d;
      cmd_q <= cmd_d;  mdat_q <= mdat_d;  ws_q <= ws_d;  take_q <= take_d;
      rdat_q <= rdat_d;  rvld_q <= rvld_d;  busy_q <= busy_d;  done_q <= done_d;
      err_q <= err_d;  nack_q <= nack_d;  alo_q <= alo_d;  hold_q <= hold_d;
`ifdef I2C_SEQ_RETRY_EN
      len_q <= len_d;  retry_q <= retry_d;  took_q <= took_d;
`endif
    end
  end

  // The write byte is presented straight through during its take cycle
  assign mdat_out      = ((state_q == S_ISSUE) && (phase_q == P_WDAT)) ? wdat_in : mdat_q;
  assign cmd_out       = cmd_q;
  assign ws_out        = ws_q;
  assign wdat_take_out = take_q;
  assign rdat_out      = rdat_q;
  assign rdat_vld_out  = rvld_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign err_out       = err_q;
  assign nack_out      = nack_q;
  assign alo_out       = alo_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq with a behavioural i2c_master responder.
`timescale 1ns/1ps
module tb_i2c_reg_seq;
  localparam int LEN_W = 4;

  logic clk, rst, req_in, rnw_in;
  logic [6:0] dev_in;
  logic [7:0] reg_in, wdat_in, rdat_out, mdat_out, mdat_in;
  logic [LEN_W-1:0] len_in;
  logic wdat_take_out, rdat_vld_out, busy_out, done_out, err_out, nack_out, alo_out, ws_out;
  logic [4:0] cmd_out;
  logic [3:0] stat_in;

  int checks, passes;
  logic [7:0] wmem [0:31];
  int wtop, widx;
  logic wpend;
  logic [7:0] rmem [0:31];
  int rtop, ridx;
  logic [12:0] log_m [0:127];
  int log_n;
  logic [7:0] rv_m [0:31];
  int rv_n, take_n, done_n;
  logic alo_req, alo_rel;
  logic [4:0] cur_cmd;
  logic [7:0] cur_dat;
  int bsy_cnt;
  logic present;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2c_reg_seq #(.LEN_W(LEN_W), .N_RETRY(3)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .rnw_in(rnw_in), .dev_in(dev_in),
    .reg_in(reg_in), .len_in(len_in), .wdat_in(wdat_in), .wdat_take_out(wdat_take_out),
    .rdat_out(rdat_out), .rdat_vld_out(rdat_vld_out), .busy_out(busy_out),
    .done_out(done_out), .err_out(err_out), .nack_out(nack_out), .alo_out(alo_out),
    .cmd_out(cmd_out), .mdat_out(mdat_out), .ws_out(ws_out), .stat_in(stat_in),
    .mdat_in(mdat_in)
  );

  assign wdat_in = wmem[widx[4:0]];

  // Master model: only device 0x3b acks; BSY for 3 cycles per command
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      stat_in <= 4'h0; mdat_in <= 8'h00; bsy_cnt <= 0; cur_cmd <= 5'h00;
      cur_dat <= 8'h00; present <= 1'b0; alo_rel <= 1'b0; ridx <= rtop;
    end else if (ws_out) begin
      if (cmd_out == 5'h00) begin
        stat_in <= 4'h0; bsy_cnt <= 0;
`ifdef I2C_SEQ_RETRY_EN
        if (alo_req) alo_rel <= 1'b1;
`endif
      end else if (alo_req && !alo_rel && cmd_out[0]) begin
        stat_in <= 4'b0110; bsy_cnt <= 0;
      end else begin
        stat_in <= 4'b0001; bsy_cnt <= 3; cur_cmd <= cmd_out; cur_dat <= mdat_out;
      end
    end else if (bsy_cnt > 0) begin
      bsy_cnt <= bsy_cnt - 1;
      if (bsy_cnt == 1) begin
        if (cur_cmd[0]) begin
          present <= (cur_dat[7:1] == 7'h3b);
          stat_in <= {(cur_dat[7:1] == 7'h3b), 3'b000};
        end else if (cur_cmd[2]) begin
          mdat_in <= rmem[ridx[4:0]]; ridx <= ridx + 1; stat_in <= 4'h0;
        end else if (cur_cmd[3]) begin
          stat_in <= {present, 3'b000};
        end else begin
          stat_in <= 4'h0;
        end
      end
    end
  end

  // Monitor: logs strobed commands, read bytes, takes and done pulses
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      widx <= wtop; wpend <= 1'b0;
    end else begin
      if (wpend) widx <= widx + 1;
      wpend <= wdat_take_out;
      if (wdat_take_out) take_n <= take_n + 1;
      if (ws_out) begin log_m[log_n[6:0]] <= {cmd_out, mdat_out}; log_n <= log_n + 1; end
      if (rdat_vld_out) begin rv_m[rv_n[4:0]] <= rdat_out; rv_n <= rv_n + 1; end
      if (done_out) done_n <= done_n + 1;
    end
  end

  task automatic do_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [LEN_W-1:0] len);
    @(negedge clk);
    req_in = 1'b1; rnw_in = rnw; dev_in = dev; reg_in = rg; len_in = len;
    @(negedge clk);
    req_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_out) begin seen = 1'b1; break; end
    end
  endtask

  task automatic push_w(input logic [7:0] b);
    wmem[wtop[4:0]] = b; wtop++;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_out, done_out, err_out, nack_out, alo_out, ws_out, wdat_take_out, rdat_vld_out} !== 8'h00)
      $display("FAIL reset_flags: got %b expected 00000000",
               {busy_out, done_out, err_out, nack_out, alo_out, ws_out, wdat_take_out, rdat_vld_out});
    else passes++;
    checks++;
    if ({cmd_out, mdat_out, rdat_out} !== 21'h0)
      $display("FAIL reset_data: got %h expected 0", {cmd_out, mdat_out, rdat_out});
    else passes++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_out, ws_out} !== 2'b00) $display("FAIL idle_after_reset: got %b expected 00", {busy_out, ws_out});
    else passes++;
  endtask

  task automatic test_write;
    int base, t0;
    bit seen;
    logic [12:0] exp [0:3];
    exp[0] = {5'h09, 8'h76}; exp[1] = {5'h08, 8'h10}; exp[2] = {5'h08, 8'hA5}; exp[3] = {5'h0A, 8'h5A};
    base = log_n; t0 = take_n;
    push_w(8'hA5); push_w(8'h5A);
    do_req(1'b0, 7'h3b, 8'h10, 4'd2);
    checks++;
    if (busy_out !== 1'b1) $display("FAIL wr_busy: got %b expected 1", busy_out); else passes++;
    wait_done(400, seen);
    checks++;
    if (seen !== 1'b1) $display("FAIL wr_done: got timeout expected done"); else passes++;
    checks++;
    if ({busy_out, err_out, nack_out, alo_out} !== 4'b0000)
      $display("FAIL wr_flags: got %b expected 0000", {busy_out, err_out, nack_out, alo_out});
    else passes++;
    @(negedge clk);
    checks++;
    if (log_n - base !== 4) $display("FAIL wr_count: got %0d expected 4", log_n - base); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_m[base + i] !== exp[i]) $display("FAIL wr_cmd%0d: got %h expected %h", i, log_m[base + i], exp[i]);
      else passes++;
    end
    checks++;
    if (take_n - t0 !== 2) $display("FAIL wr_takes: got %0d expected 2", take_n - t0); else passes++;
  endtask

  task automatic test_read;
    int base, r0;
    bit seen;
    logic [12:0] exp [0:4];
    exp[0] = {5'h09, 8'h76}; exp[1] = {5'h08, 8'h10}; exp[2] = {5'h09, 8'h77};
    exp[3] = {5'h04, 8'hFF}; exp[4] = {5'h16, 8'hFF};
    rmem[rtop[4:0]] = 8'h55; rtop++; rmem[rtop[4:0]] = 8'h56; rtop++;
    base = log_n; r0 = rv_n;
    do_req(1'b1, 7'h3b, 8'h10, 4'd2);
    wait_done(400, seen);
    checks++;
    if (seen !== 1'b1) $display("FAIL rd_done: got timeout expected done"); else passes++;
    checks++;
    if ({err_out, nack_out, alo_out} !== 3'b000)
      $display("FAIL rd_flags: got %b expected 000", {err_out, nack_out, alo_out});
    else passes++;
    @(negedge clk);
    checks++;
    if (log_n - base !== 5) $display("FAIL rd_count: got %0d expected 5", log_n - base); else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_m[base + i] !== exp[i]) $display("FAIL rd_cmd%0d: got %h expected %h", i, log_m[base + i], exp[i]);
      else passes++;
    end
    checks++;
    if (rv_n - r0 !== 2) $display("FAIL rd_vld_count: got %0d expected 2", rv_n - r0); else passes++;
    checks++;
    if ({rv_m[r0], rv_m[r0 + 1]} !== 16'h5556)
      $display("FAIL rd_bytes: got %h expected 5556", {rv_m[r0], rv_m[r0 + 1]});
    else passes++;
  endtask

  task automatic test_nack;
    int base, t0;
    bit seen;
    base = log_n; t0 = take_n;
    do_req(1'b0, 7'h22, 8'h10, 4'd2);
    wait_done(400, seen);
    checks++;
    if (seen !== 1'b1) $display("FAIL nack_done: got timeout expected done"); else passes++;
    checks++;
    if ({err_out, nack_out, alo_out} !== 3'b110)
      $display("FAIL nack_flags: got %b expected 110", {err_out, nack_out, alo_out});
    else passes++;
    @(negedge clk);
    checks++;
    if (log_n - base !== 2) $display("FAIL nack_count: got %0d expected 2", log_n - base); else passes++;
    checks++;
    if ({log_m[base], log_m[base + 1]} !== {5'h09, 8'h44, 5'h02, 8'h00})
      $display("FAIL nack_cmds: got %h %h expected 0944 0200", log_m[base], log_m[base + 1]);
    else passes++;
    checks++;
    if (take_n - t0 !== 0) $display("FAIL nack_takes: got %0d expected 0", take_n - t0); else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if ({err_out, nack_out} !== 2'b11) $display("FAIL nack_held: got %b expected 11", {err_out, nack_out});
    else passes++;
  endtask

  task automatic test_alo;
    int base;
    bit seen;
    base = log_n;
    alo_req = 1'b1;
`ifdef I2C_SEQ_RETRY_EN
    push_w(8'hA5); push_w(8'h5A);
`endif
    do_req(1'b0, 7'h3b, 8'h10, 4'd2);
    wait_done(600, seen);
    alo_req = 1'b0;
    checks++;
    if (seen !== 1'b1) $display("FAIL alo_done: got timeout expected done"); else passes++;
    @(negedge clk);
    checks++;
    if (log_m[base + 1] !== {5'h00, 8'h00})
      $display("FAIL alo_clr_cmd: got %h expected 0000", log_m[base + 1]);
    else passes++;
`ifdef I2C_SEQ_RETRY_EN
    checks++;
    if ({err_out, nack_out, alo_out} !== 3'b000)
      $display("FAIL alo_flags: got %b expected 000", {err_out, nack_out, alo_out});
    else passes++;
    checks++;
    if (log_n - base !== 6) $display("FAIL alo_count: got %0d expected 6", log_n - base); else passes++;
    checks++;
    if (log_m[base + 5] !== {5'h0A, 8'h5A}) $display("FAIL alo_last: got %h expected 0a5a", log_m[base + 5]);
    else passes++;
`else
    checks++;
    if ({err_out, nack_out, alo_out} !== 3'b101)
      $display("FAIL alo_flags: got %b expected 101", {err_out, nack_out, alo_out});
    else passes++;
    checks++;
    if (log_n - base !== 2) $display("FAIL alo_count: got %0d expected 2", log_n - base); else passes++;
`endif
  endtask

  task automatic test_back_to_back;
    int base, d0;
    bit seen;
    logic [12:0] exp [0:3];
    exp[0] = {5'h09, 8'h76}; exp[1] = {5'h08, 8'h10}; exp[2] = {5'h08, 8'hA5}; exp[3] = {5'h0A, 8'h5A};
    base = log_n; d0 = done_n;
    push_w(8'hA5); push_w(8'h5A);
    do_req(1'b0, 7'h3b, 8'h10, 4'd2);
    repeat (4) @(negedge clk);
    checks++;
    if (busy_out !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", busy_out); else passes++;
    do_req(1'b1, 7'h22, 8'h33, 4'd0);
    wait_done(400, seen);
    checks++;
    if ({seen, err_out} !== 2'b10) $display("FAIL b2b_done: got %b expected 10", {seen, err_out}); else passes++;
    repeat (20) @(negedge clk);
    checks++;
    if (log_n - base !== 4) $display("FAIL b2b_count: got %0d expected 4", log_n - base); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_m[base + i] !== exp[i]) $display("FAIL b2b_cmd%0d: got %h expected %h", i, log_m[base + i], exp[i]);
      else passes++;
    end
    checks++;
    if (done_n - d0 !== 1) $display("FAIL b2b_dones: got %0d expected 1", done_n - d0); else passes++;
  endtask

  task automatic test_read_len0;
    int base;
    bit seen;
    base = log_n;
    do_req(1'b1, 7'h3b, 8'h10, 4'd0);
    wait_done(20, seen);
    checks++;
    if ({seen, err_out, nack_out, alo_out} !== 4'b1100)
      $display("FAIL len0_flags: got %b expected 1100", {seen, err_out, nack_out, alo_out});
    else passes++;
    @(negedge clk);
    checks++;
    if (log_n - base !== 0) $display("FAIL len0_ws: got %0d expected 0", log_n - base); else passes++;
  endtask

  task automatic test_async_reset;
    int base;
    bit seen, hit;
    push_w(8'h11); push_w(8'h22);
    do_req(1'b0, 7'h3b, 8'h10, 4'd2);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wdat_take_out) begin hit = 1'b1; break; end
    end
    checks++;
    if (hit !== 1'b1) $display("FAIL ar_take: got timeout expected take"); else passes++;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({busy_out, done_out, err_out, nack_out, alo_out, ws_out, wdat_take_out, rdat_vld_out,
         cmd_out, mdat_out} !== 21'h0)
      $display("FAIL ar_outputs: got %h expected 0", {busy_out, done_out, err_out, nack_out, alo_out,
               ws_out, wdat_take_out, rdat_vld_out, cmd_out, mdat_out});
    else passes++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = log_n;
    push_w(8'hA5); push_w(8'h5A);
    do_req(1'b0, 7'h3b, 8'h10, 4'd2);
    wait_done(400, seen);
    checks++;
    if ({seen, err_out} !== 2'b10) $display("FAIL ar_redo: got %b expected 10", {seen, err_out}); else passes++;
    @(negedge clk);
    checks++;
    if ({log_m[base + 2], log_m[base + 3]} !== {5'h08, 8'hA5, 5'h0A, 8'h5A})
      $display("FAIL ar_bytes: got %h %h expected 08a5 0a5a", log_m[base + 2], log_m[base + 3]);
    else passes++;
  endtask

  initial begin
    checks = 0; passes = 0;
    req_in = 1'b0; rnw_in = 1'b0; dev_in = 7'h00; reg_in = 8'h00; len_in = '0;
    alo_req = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_alo();
    test_back_to_back();
    test_read_len0();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/i2c_reg_seq.md
Name: i2c_reg_seq

Overview:
Register-access sequencer that sits directly upstream of i2c_master. It turns one host request (device, register, length, read/write) into the master's command/strobe sequence: START+address, register byte, optional repeated START, then data bytes. It moves data bytes through simple pulse handshakes, detects NACK and arbitration loss, and always leaves the master idle with its status cleared.

Parameters:
LEN_W, 4, width of the byte-count field; max transfer length is 2^LEN_W-1 bytes.
N_RETRY, 3, arbitration-loss retries; used only with I2C_SEQ_RETRY_EN.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  reset, asynchronous, active-low.
req_in  in  1  1-cycle request pulse; sampled only in IDLE.
rnw_in  in  1  1 = register read, 0 = register write.
dev_in  in  7  7-bit device address.
reg_in  in  8  register address.
len_in  in  LEN_W  number of data bytes.
wdat_in  in  8  write byte; must be valid during the cycle wdat_take_out=1.
wdat_take_out  out  1  1-cycle pulse; wdat_in is consumed in this cycle.
rdat_out  out  8  read byte.
rdat_vld_out  out  1  1-cycle pulse; rdat_out is valid.
busy_out  out  1  high from request acceptance until done_out.
done_out  out  1  1-cycle completion pulse.
err_out, nack_out, alo_out  out  1 each  result flags; valid at done_out; held until the next accepted req_in.
cmd_out  out  5  master command: bit0 STRT, bit1 STOP, bit2 READ, bit3 WRTE, bit4 NACK; 0 = CLRS.
mdat_out  out  8  master data input.
ws_out  out  1  master write strobe.
stat_in  in  4  master status: bit0 BSY, bit1 ERR, bit2 ALO, bit3 ACK.
mdat_in  in  8  master read data.

Behaviour:
- Reset: all outputs 0, state IDLE, flags cleared.
- States: IDLE, ISSUE, WAITS, WAITD, EVAL, STOPX, CLR, FIN.
- IDLE:
  - On req_in: latch all request inputs, clear flags, set busy_out, go to ISSUE.
  - rnw_in=1 with len_in=0: skip to FIN with err_out=1; no bus activity.
  - req_in while busy is ignored.
- ISSUE: drive ws_out=1 for exactly 1 cycle. cmd_out/mdat_out are registered, stable from this cycle until the next ISSUE. Go to WAITS.
- WAITS: wait for stat_in BSY=1 (go to WAITD) or ERR=1 (go to EVAL).
- WAITD: wait for BSY=0, then go to EVAL.
- Phase sequence (cmd hex / data), count = bytes remaining:
  - ADDR: 0x09 / {dev,0}.
  - REG: 0x08 / reg. If write and len=0, use 0x0A instead.
  - WDAT: 0x08 / wdat_in; last byte uses 0x0A. wdat_take_out pulses in the ISSUE cycle.
  - RADDR (read only): 0x09 / {dev,1}.
  - RDAT: 0x04 / 0xFF; last byte uses 0x16.
- EVAL:
  - ERR=1: latch alo_out=ALO, set err_out, go to CLR.
  - Write phase (ADDR/REG/WDAT/RADDR) with ACK=0 and STOP not already sent: set nack_out and err_out, go to STOPX.
  - Write phase with ACK=0 when STOP was already sent (last-byte write): set nack_out and err_out, go to FIN.
  - RDAT: capture mdat_in into rdat_out and pulse rdat_vld_out in the EVAL cycle; read ACK is ignored.
  - Otherwise advance to the next phase (ISSUE), or to FIN after the last phase.
- STOPX: issue 0x02 (stop only) via the ISSUE/WAITS/WAITD path, then go to FIN.
- CLR: issue cmd 0 with ws_out=1 for 1 cycle; do not wait for BSY; hold 1 cycle, then go to FIN.
- FIN: pulse done_out, clear busy_out, return to IDLE.
- Byte counter: LEN_W bits, decremented per data byte; the last byte is the one issued at count==1. No wrap is possible.
- Async reset mid-transfer: return to IDLE immediately. The master is reset by the same signal, so no STOP is issued.

Optional Feature:
I2C_SEQ_RETRY_EN
- Defined:
  - An ALO error runs CLR, then restarts the whole transaction from ADDR, up to N_RETRY times.
  - The WDAT byte source is not rewound. Retry is allowed only if no WDAT byte has been taken yet; otherwise the sequencer reports the error.
  - alo_out is set only when retries are exhausted.
- Undefined: ALO reports immediately, with err_out=1 and alo_out=1.

Test Plan:
- Write, dev=0x3b, reg=0x10, len=2, bytes 0xA5,0x5A -> commands 09/76, 08/10, 08/A5, 0A/5A; two wdat_take_out pulses; done_out with err=0.
- Read, dev=0x3b, reg=0x10, len=2, slave returns 0x55,0x56 -> commands 09/76, 08/10, 09/77, 04, 16; two rdat_vld_out pulses with 0x55, 0x56; err=0.
- Write, dev=0x22 (absent) -> after 09/44 the next command is 02 (stop only); nack_out=1, err_out=1; zero wdat_take_out pulses.
- SDA forced low by a second driver during the ADDR phase -> master ALO; ws_out with cmd=0 follows; err=1, alo=1. With I2C_SEQ_RETRY_EN, releasing SDA makes the retry succeed with err=0.
- rst low for 3 cycles during WDAT -> all outputs 0 on the asynchronous assertion. After release, a new write request completes normally. A read request with len=0 -> done_out with err=1 and no ws_out.
- req_in pulsed while busy_out=1 -> ignored; the command trace is identical to the single-request case.
